mem_bus_arbiter: RTL and testbench

//  Shares the single external memory bus between three requesters: paging unit (PG),
//  EXE->MEM data stage (MEM) and instruction fetch (IF). One transaction at a time,

---
 rtl/mem_bus_arbiter.sv | 194 +++++++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Shares one external memory bus between the paging unit (PG), the MEM data
//   stage and instruction fetch (IF). One transaction at a time, fixed priority
//   PG > MEM > IF, except that IF is forced to win once after STARVE_LIMIT
//   consecutive lost arbitrations. FSM: IDLE -> ACCESS -> DONE -> IDLE.
//
//   Parameters: STARVE_LIMIT (1..15), TIMEOUT (bus wait limit, timeout build only)
//   Ports:
//     CLK, RST                 clock, synchronous active-high reset
//     if_req/if_addr/if_done   IF read requester
//     mem_req/we/addr/wdata    MEM-stage requester, mem_done completion pulse
//     pg_req/we/addr/wdata     paging requester, pg_done completion pulse
//     rdata                    registered read data, valid in any *_done cycle
//     bus_addr/wdata/rd/wr     external bus; strobes held until bus_ready
//     bus_ready/bus_rdata      memory completion handshake and read data
//     mem_pipe_stall           mem_req & ~mem_done
//     owner                    0 none, 1 IF, 2 MEM, 3 PG
//     timeout_err              pulse in the DONE cycle of an aborted access
//   Optional feature: define MEM_ARB_TIMEOUT_EN to abort accesses that see no
//   bus_ready within TIMEOUT cycles (rdata forced to 8'hFF).
module mem_bus_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int TIMEOUT      = 15
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic        if_done,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [15:0] mem_addr,
  input  logic [7:0]  mem_wdata,
  output logic        mem_done,
  input  logic        pg_req,
  input  logic        pg_we,
  input  logic [15:0] pg_addr,
  input  logic [7:0]  pg_wdata,
  output logic        pg_done,
  output logic [7:0]  rdata,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_wdata,
  output logic        bus_rd,
  output logic        bus_wr,
  input  logic        bus_ready,
  input  logic [7:0]  bus_rdata,
  output logic        mem_pipe_stall,
  output logic [1:0]  owner,
  output logic        timeout_err
);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_MEM  = 2'd2;
  localparam logic [1:0] OWN_PG   = 2'd3;

  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15 || TIMEOUT < 1) begin : g_bad_param
    $error("mem_bus_arbiter: STARVE_LIMIT must be 1..15 and TIMEOUT >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  typedef struct packed {
    logic [1:0]  id;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_req_t;

  state_t     state_q, state_d;
  bus_req_t   grant;
  logic [3:0] starve_cnt;
  logic       bus_we_q;
  logic       force_if;
  logic       timeout_hit;

  // Winner of an IDLE-cycle arbitration; id==OWN_NONE when nobody asks.
  always_comb begin
    grant    = '0;
    force_if = if_req && (starve_cnt == 4'(STARVE_LIMIT));
    if (force_if) begin
      grant.id   = OWN_IF;
      grant.addr = if_addr;
    end else if (pg_req) begin
      grant.id    = OWN_PG;
      grant.we    = pg_we;
      grant.addr  = pg_addr;
      grant.wdata = pg_wdata;
    end else if (mem_req) begin
      grant.id    = OWN_MEM;
      grant.we    = mem_we;
      grant.addr  = mem_addr;
      grant.wdata = mem_wdata;
    end else if (if_req) begin
      grant.id   = OWN_IF;
      grant.addr = if_addr;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (grant.id != OWN_NONE) state_d = S_ACCESS;
      S_ACCESS: if (bus_ready || timeout_hit) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      owner      <= OWN_NONE;
      bus_addr   <= '0;
      bus_wdata  <= '0;
      bus_we_q   <= 1'b0;
      rdata      <= '0;
      starve_cnt <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          owner <= grant.id;
          if (grant.id != OWN_NONE) begin
            bus_addr  <= grant.addr;
            bus_wdata <= grant.wdata;
            bus_we_q  <= grant.we;
          end
          // if_req high here means IF took part in this arbitration.
          if (!if_req || grant.id == OWN_IF)
            starve_cnt <= '0;
          else if (starve_cnt != 4'(STARVE_LIMIT))
            starve_cnt <= starve_cnt + 4'd1;
        end
        S_ACCESS: begin
          if (bus_ready) begin
            if (!bus_we_q) rdata <= bus_rdata;
          end else if (timeout_hit) begin
            rdata <= 8'hFF;
          end
        end
        S_DONE:  owner <= OWN_NONE;
        default: ;
      endcase
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] wait_cnt;
  logic          to_flag;

  always_ff @(posedge CLK) begin
    if (RST) begin
      wait_cnt <= '0;
      to_flag  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          wait_cnt <= '0;
          to_flag  <= 1'b0;
        end
        S_ACCESS: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (timeout_hit) to_flag <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // wait_cnt counts completed ACCESS cycles, so TIMEOUT-1 marks the last one.
  assign timeout_hit = (state_q == S_ACCESS) && !bus_ready &&
                       (wait_cnt == TW'(TIMEOUT - 1));
  assign timeout_err = (state_q == S_DONE) && to_flag;
`else
  assign timeout_hit = 1'b0;
  assign timeout_err = 1'b0;
`endif

  // Strobes follow the state register so a reset edge drops them immediately.
  assign bus_rd = (state_q == S_ACCESS) && !bus_we_q;
  assign bus_wr = (state_q == S_ACCESS) &&  bus_we_q;

  assign if_done  = (state_q == S_DONE) && (owner == OWN_IF);
  assign mem_done = (state_q == S_DONE) && (owner == OWN_MEM);
  assign pg_done  = (state_q == S_DONE) && (owner == OWN_PG);

  assign mem_pipe_stall = mem_req && !mem_done;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: expected transactions are queued when requests are
// raised and checked by a monitor at each *_done pulse; a behavioural memory
// answers bus strobes after a programmable latency.
module tb_mem_bus_arbiter;
  localparam int STARVE_LIMIT = 4;
  localparam int TIMEOUT      = 15;

  logic        CLK = 1'b0, RST = 1'b1;
  logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, pg_req = 1'b0, pg_we = 1'b0;
  logic [15:0] if_addr = '0, mem_addr = '0, pg_addr = '0;
  logic [7:0]  mem_wdata = '0, pg_wdata = '0;
  logic        bus_ready = 1'b0;
  logic [7:0]  bus_rdata = '0;
  logic        if_done, mem_done, pg_done, bus_rd, bus_wr, mem_pipe_stall, timeout_err;
  logic [7:0]  rdata, bus_wdata;
  logic [15:0] bus_addr;
  logic [1:0]  owner;

  mem_bus_arbiter #(.STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .RST(RST),
    .if_req(if_req), .if_addr(if_addr), .if_done(if_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_done(mem_done),
    .pg_req(pg_req), .pg_we(pg_we), .pg_addr(pg_addr), .pg_wdata(pg_wdata), .pg_done(pg_done),
    .rdata(rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_rd(bus_rd), .bus_wr(bus_wr),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata), .mem_pipe_stall(mem_pipe_stall),
    .owner(owner), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0]  own;
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        to;
  } exp_t;

  exp_t       sbq[$];
  int         vec = 0, err = 0;
  logic [7:0] model_rdata = 8'h00;
  int         lat = 0;
  bit         resp_en = 1'b1;
  int         rcnt = 0;
  bit         stall_bad = 1'b0;
  logic       seen_we = 1'b0;
  logic [7:0] seen_wdata = 8'h00;

  function automatic logic [7:0] mem_fn(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h7C;  // 0x1234 -> 0x5A
  endfunction

  function automatic exp_t mk(input logic [1:0] own, input logic we, input logic [15:0] addr,
                              input logic [7:0] wdata, input logic to);
    exp_t e;
    e.own = own; e.we = we; e.addr = addr; e.wdata = wdata; e.to = to;
    return e;
  endfunction

  // Behavioural memory: ready after 'lat' strobe cycles, junk data otherwise.
  always @(negedge CLK) begin
    if (bus_rd || bus_wr) begin
      if (resp_en && rcnt == lat) begin
        bus_ready = 1'b1;
        bus_rdata = mem_fn(bus_addr);
      end else begin
        bus_ready = 1'b0;
        bus_rdata = 8'hEE;
      end
      rcnt++;
    end else begin
      rcnt      = 0;
      bus_ready = 1'b0;
    end
  end

  // Completion monitor / scoreboard.
  always @(negedge CLK) begin
    exp_t       e;
    logic [1:0] own;
    logic [7:0] er;
    if (bus_rd || bus_wr) begin
      seen_we    = bus_wr;
      seen_wdata = bus_wdata;
    end
    if (!(if_done || mem_done || pg_done) && timeout_err !== 1'b0) begin
      err++;
      $display("FAIL stray_timeout_err: got %b want 0", timeout_err);
    end
    if (if_done || mem_done || pg_done) begin
      own = pg_done ? 2'd3 : (mem_done ? 2'd2 : 2'd1);
      vec++;
      if ({if_done, mem_done, pg_done} != 3'b100 && {if_done, mem_done, pg_done} != 3'b010 &&
          {if_done, mem_done, pg_done} != 3'b001) begin
        err++;
        $display("FAIL done_onehot: got %b want one-hot", {if_done, mem_done, pg_done});
      end
      if (sbq.size() == 0) begin
        vec++; err++;
        $display("FAIL unexpected_done: got done for owner %0d want none", own);
      end else begin
        e  = sbq.pop_front();
        er = e.to ? 8'hFF : (e.we ? model_rdata : mem_fn(e.addr));
        model_rdata = er;
        vec += 5;
        if (own !== e.own) begin err++; $display("FAIL done_owner: got %0d want %0d", own, e.own); end
        if (owner !== e.own) begin err++; $display("FAIL owner_in_done: got %0d want %0d", owner, e.own); end
        if (bus_addr !== e.addr) begin err++; $display("FAIL bus_addr: got %h want %h", bus_addr, e.addr); end
        if (seen_we !== e.we) begin err++; $display("FAIL bus_dir: got wr=%b want %b", seen_we, e.we); end
        if (rdata !== er) begin err++; $display("FAIL rdata: got %h want %h", rdata, er); end
        if (e.we) begin
          vec++;
          if (seen_wdata !== e.wdata) begin err++; $display("FAIL bus_wdata: got %h want %h", seen_wdata, e.wdata); end
        end
        vec++;
        if (timeout_err !== e.to) begin err++; $display("FAIL timeout_err: got %b want %b", timeout_err, e.to); end
      end
    end
  end

  task automatic wait_dones(input int n, input bit hold, output int first_c, output int last_c);
    int got = 0;
    int c   = 0;
    first_c = -1; last_c = -1;
    while (got < n && c < 300) begin
      @(negedge CLK);
      c++;
      if (mem_pipe_stall !== (mem_req & ~mem_done)) stall_bad = 1'b1;
      if (if_done || mem_done || pg_done) begin
        got++;
        if (got == 1) first_c = c;
        last_c = c;
        if (!hold) begin
          if (if_done)  if_req  = 1'b0;
          if (mem_done) mem_req = 1'b0;
          if (pg_done)  pg_req  = 1'b0;
        end
      end
    end
    if (got < n) begin
      vec++; err++;
      $display("FAIL wait_dones: got %0d dones want %0d within budget", got, n);
    end
    if (hold) begin if_req = 1'b0; mem_req = 1'b0; pg_req = 1'b0; end
  endtask

  task automatic check_drained(input string name);
    repeat (2) @(negedge CLK);
    vec++;
    if (sbq.size() != 0) begin
      err++; $display("FAIL %s_drain: got %0d pending want 0", name, sbq.size()); sbq.delete();
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    vec += 3;
    if (owner !== 2'd0 || bus_rd !== 1'b0 || bus_wr !== 1'b0) begin
      err++; $display("FAIL reset_ctrl: got owner=%0d rd=%b wr=%b want 0 0 0", owner, bus_rd, bus_wr);
    end
    if (rdata !== 8'h00 || bus_addr !== 16'h0 || bus_wdata !== 8'h00) begin
      err++; $display("FAIL reset_data: got rdata=%h addr=%h wdata=%h want 0", rdata, bus_addr, bus_wdata);
    end
    if ({if_done, mem_done, pg_done, timeout_err, mem_pipe_stall} !== 5'b0) begin
      err++; $display("FAIL reset_pulses: got %b want 00000", {if_done, mem_done, pg_done, timeout_err, mem_pipe_stall});
    end
    RST = 1'b0;
  endtask

  task automatic test_single_if();
    int  c = 0, strb = 0;
    bit  first = 1'b1, done = 1'b0;
    lat = 2;
    if_addr = 16'h1234;
    sbq.push_back(mk(2'd1, 1'b0, 16'h1234, 8'h00, 1'b0));
    if_req = 1'b1;
    while (!done && c < 50) begin
      @(negedge CLK);
      c++;
      if (bus_rd) begin
        strb++;
        if (first) begin
          first = 1'b0;
          vec++;
          if (owner !== 2'd1 || bus_addr !== 16'h1234 || bus_wr !== 1'b0) begin
            err++; $display("FAIL if_access: got owner=%0d addr=%h wr=%b want 1 1234 0", owner, bus_addr, bus_wr);
          end
        end
      end
      if (if_done) begin
        done = 1'b1;
        if_req = 1'b0;
        vec += 2;
        if (rdata !== 8'h5A) begin err++; $display("FAIL if_rdata: got %h want 5a", rdata); end
        if (strb != 3) begin err++; $display("FAIL if_strobe_len: got %0d want 3", strb); end
      end
    end
    if (!done) begin vec++; err++; $display("FAIL if_done_wait: got no if_done want one"); end
    @(negedge CLK);
    vec++;
    if (owner !== 2'd0 || if_done !== 1'b0) begin
      err++; $display("FAIL if_after: got owner=%0d if_done=%b want 0 0", owner, if_done);
    end
    check_drained("single_if");
  endtask

  task automatic test_priority();
    int f, l;
    lat = 1;
    stall_bad = 1'b0;
    pg_we = 1'b1;  pg_addr = 16'hA000; pg_wdata = 8'hC3;
    mem_we = 1'b0; mem_addr = 16'h0042;
    if_addr = 16'h0100;
    sbq.push_back(mk(2'd3, 1'b1, 16'hA000, 8'hC3, 1'b0));
    sbq.push_back(mk(2'd2, 1'b0, 16'h0042, 8'h00, 1'b0));
    sbq.push_back(mk(2'd1, 1'b0, 16'h0100, 8'h00, 1'b0));
    pg_req = 1'b1; mem_req = 1'b1; if_req = 1'b1;
    wait_dones(3, 1'b0, f, l);
    vec++;
    if (stall_bad) begin err++; $display("FAIL mem_pipe_stall: got mismatch vs mem_req&~mem_done want none"); end
    pg_we = 1'b0;
    check_drained("priority");
  endtask

  task automatic test_starve();
    int f, l;
    lat = 0;
    mem_we = 1'b0; mem_addr = 16'h0300; if_addr = 16'h0400;
    for (int i = 0; i < STARVE_LIMIT; i++) sbq.push_back(mk(2'd2, 1'b0, 16'h0300, 8'h00, 1'b0));
    sbq.push_back(mk(2'd1, 1'b0, 16'h0400, 8'h00, 1'b0));
    mem_req = 1'b1; if_req = 1'b1;
    wait_dones(STARVE_LIMIT + 1, 1'b1, f, l);
    check_drained("starve");
  endtask

  task automatic test_back_to_back();
    int f, l;
    lat = 0;
    mem_we = 1'b1; mem_addr = 16'h0BEE; mem_wdata = 8'h3C;
    sbq.push_back(mk(2'd2, 1'b1, 16'h0BEE, 8'h3C, 1'b0));
    sbq.push_back(mk(2'd2, 1'b1, 16'h0BEE, 8'h3C, 1'b0));
    mem_req = 1'b1;
    wait_dones(2, 1'b1, f, l);
    // req raised before edge N: IDLE, ACCESS, DONE -> done in 2nd cycle after raising
    vec += 2;
    if (f != 2) begin err++; $display("FAIL min_latency: got %0d want 2", f); end
    if (l - f != 3) begin err++; $display("FAIL b2b_spacing: got %0d want 3", l - f); end
    mem_we = 1'b0;
    check_drained("b2b");
  endtask

  task automatic test_reset_mid_access();
    int  c = 0;
    bit  dbad = 1'b0;
    resp_en = 1'b0;
    mem_we = 1'b0; mem_addr = 16'h0555;
    mem_req = 1'b1;
    while (!bus_rd && c < 10) begin @(negedge CLK); c++; end
    vec++;
    if (!bus_rd) begin err++; $display("FAIL rst_mid_start: got rd=%b want 1", bus_rd); end
    @(negedge CLK);
    RST = 1'b1;
    mem_req = 1'b0;
    @(negedge CLK);
    vec += 2;
    if (bus_rd !== 1'b0 || bus_wr !== 1'b0 || owner !== 2'd0) begin
      err++; $display("FAIL rst_mid_ctrl: got rd=%b wr=%b owner=%0d want 0 0 0", bus_rd, bus_wr, owner);
    end
    if (rdata !== 8'h00) begin err++; $display("FAIL rst_mid_rdata: got %h want 00", rdata); end
    for (int i = 0; i < 3; i++) begin
      if (if_done || mem_done || pg_done) dbad = 1'b1;
      @(negedge CLK);
    end
    vec++;
    if (dbad) begin err++; $display("FAIL rst_mid_done: got done pulse want none"); end
    model_rdata = 8'h00;
    RST = 1'b0;
    resp_en = 1'b1;
    check_drained("rst_mid");
  endtask

`ifdef MEM_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int c = 0, strb = 0;
    bit done = 1'b0;
    resp_en = 1'b0;
    mem_we = 1'b0; mem_addr = 16'h0777;
    sbq.push_back(mk(2'd2, 1'b0, 16'h0777, 8'h00, 1'b1));
    mem_req = 1'b1;
    while (!done && c < 60) begin
      @(negedge CLK);
      c++;
      if (bus_rd) strb++;
      if (mem_done) begin
        done = 1'b1;
        mem_req = 1'b0;
        vec += 3;
        if (strb != TIMEOUT) begin err++; $display("FAIL to_strobe_len: got %0d want %0d", strb, TIMEOUT); end
        if (timeout_err !== 1'b1) begin err++; $display("FAIL to_err: got %b want 1", timeout_err); end
        if (rdata !== 8'hFF) begin err++; $display("FAIL to_rdata: got %h want ff", rdata); end
      end
    end
    if (!done) begin vec++; err++; $display("FAIL to_wait: got no mem_done want one"); end
    resp_en = 1'b1;
    check_drained("timeout");
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_if();
    test_priority();
    test_starve();
    test_back_to_back();
    test_reset_mid_access();
`ifdef MEM_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
